// File: rtl/aes_pkg.sv
// Shared AES-128 constants, types and the round-constant lookup.
package aes_pkg;

  localparam int unsigned AES_NK = 4;
  localparam int unsigned AES_NR = 10;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  function automatic logic [7:0] aes_rcon(input logic [3:0] r);
    logic [7:0] rc;
    case (r)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: previous round key + Rcon byte -> next round key.
module aes_key_round
  import aes_pkg::*;
(
  input  logic [127:0] i_prev_rk,
  input  logic [7:0]   i_rcon,
  output logic [127:0] o_next_rk
);

  word_t w0, w1, w2, w3;
  word_t rot;
  word_t sub;
  word_t t;
  word_t n0, n1, n2, n3;

  assign w0  = i_prev_rk[127:96];
  assign w1  = i_prev_rk[95:64];
  assign w2  = i_prev_rk[63:32];
  assign w3  = i_prev_rk[31:0];
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (rot[8*g +: 8]),
      .o_byte (sub[8*g +: 8])
    );
  end

  always_comb begin
    t  = sub ^ {i_rcon, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    o_next_rk = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_sbox.sv
// Combinational AES S-box: GF(2^8) inverse (x^254) followed by the affine map.
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Square-and-multiply for x^254; maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] base;
    logic [7:0] e;
    r    = 8'h01;
    base = a;
    e    = 8'd254;
    for (int unsigned i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  logic [7:0] inv;

  always_comb begin
    inv    = gf_inv(i_byte);
    o_byte = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128 key schedule: accepts a cipher key, streams round keys 0..10 over a valid/ready handshake.
module aes_key_schedule
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [127:0] i_key,
  input  logic         i_key_valid,
  output logic         o_key_ready,
  output logic [127:0] o_rk,
  output logic [3:0]   o_rk_idx,
  output logic         o_rk_last,
  output logic         o_rk_valid,
  input  logic         i_rk_ready
);

  if (NR != AES_NR) begin : g_nr_check
    $error("aes_key_schedule supports only NR = 10 (AES-128)");
  end

  state_e       state_q, state_d;
  logic         key_ready_q, key_ready_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0]   idx_q, idx_d;
  logic         last_q, last_d;
  logic         valid_q, valid_d;
  logic [127:0] next_rk;
  logic [7:0]   rcon;

  assign rcon = aes_rcon(idx_q + 4'd1);

  aes_key_round u_round (
    .i_prev_rk (rk_q),
    .i_rcon    (rcon),
    .o_next_rk (next_rk)
  );

  always_comb begin
    state_d     = state_q;
    key_ready_d = key_ready_q;
    rk_d        = rk_q;
    idx_d       = idx_q;
    last_d      = last_q;
    valid_d     = valid_q;
    case (state_q)
      IDLE: begin
        if (i_key_valid && key_ready_q) begin
          rk_d        = i_key;
          idx_d       = '0;
          last_d      = 1'b0;
          valid_d     = 1'b1;
          key_ready_d = 1'b0;
          state_d     = STREAM;
        end
      end
      STREAM: begin
        if (valid_q && i_rk_ready) begin
          if (last_q) begin
            valid_d     = 1'b0;
            key_ready_d = 1'b1;
            state_d     = IDLE;
          end else begin
            rk_d   = next_rk;
            idx_d  = idx_q + 4'd1;
            last_d = (idx_q == 4'(NR - 1));
          end
        end
      end
      default: begin
        state_d     = IDLE;
        key_ready_d = 1'b1;
        valid_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b1;
      rk_q        <= '0;
      idx_q       <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      rk_q        <= rk_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
    end
  end

  assign o_key_ready = key_ready_q;
  assign o_rk        = rk_q;
  assign o_rk_idx    = idx_q;
  assign o_rk_last   = last_q;
  assign o_rk_valid  = valid_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Randomized bench for aes_key_schedule against a word-array key-expansion model.
module tb_aes_key_schedule;

  logic         clk;
  logic         rst_n;
  logic [127:0] i_key;
  logic         i_key_valid;
  logic         o_key_ready;
  logic [127:0] o_rk;
  logic [3:0]   o_rk_idx;
  logic         o_rk_last;
  logic         o_rk_valid;
  logic         i_rk_ready;

  aes_key_schedule #(.NR(10)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_key       (i_key),
    .i_key_valid (i_key_valid),
    .o_key_ready (o_key_ready),
    .o_rk        (o_rk),
    .o_rk_idx    (o_rk_idx),
    .o_rk_last   (o_rk_last),
    .o_rk_valid  (o_rk_valid),
    .i_rk_ready  (i_rk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0]   sbox [256];
  logic [127:0] model_rk [11];
  logic [127:0] got_rk [11];
  int unsigned  hs_cnt;
  int unsigned  vcyc;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // S-box table from the generator-3 walk over GF(2^8) and its inverse walk.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sbox[p] = x ^ 8'h63;
    end
    sbox[0] = 8'h63;
  endtask

  task automatic expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic start(input logic [127:0] key);
    @(negedge clk);
    check_eq("start_key_ready", {127'b0, o_key_ready}, 128'd1);
    i_key       = key;
    i_key_valid = 1'b1;
  endtask

  // Consume one stream; ready is high with probability pct%. In hold mode key2 is offered throughout.
  task automatic drain(input logic [127:0] key, input int unsigned pct,
                       input bit hold, input logic [127:0] key2);
    bit done;
    bit rdy;
    expand(key);
    hs_cnt = 0;
    vcyc   = 0;
    done   = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      i_key_valid = hold;
      i_key       = hold ? key2 : key;
      if (!o_rk_valid) begin
        done = 1'b1;
      end else begin
        vcyc++;
        check_eq("rk_idx", {124'b0, o_rk_idx}, 128'(hs_cnt));
        check_eq("rk_last", {127'b0, o_rk_last}, {127'b0, (hs_cnt == 10)});
        check_eq("key_ready_busy", {127'b0, o_key_ready}, 128'd0);
        if (hs_cnt <= 10) begin
          check_eq("rk_value", o_rk, model_rk[hs_cnt]);
          got_rk[hs_cnt] = o_rk;
        end
        rdy = ($urandom_range(99) < pct);
        i_rk_ready = rdy;
        if (rdy) hs_cnt++;
      end
    end
    check_eq("stream_ended", {127'b0, done}, 128'd1);
    check_eq("handshakes", 128'(hs_cnt), 128'd11);
    check_eq("idle_key_ready", {127'b0, o_key_ready}, 128'd1);
    i_rk_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] k1, k2;
    bit found;
    rst_n       = 1'b0;
    i_key       = '0;
    i_key_valid = 1'b0;
    i_rk_ready  = 1'b0;
    build_sbox();
    repeat (2) @(negedge clk);
    check_eq("rst_key_ready", {127'b0, o_key_ready}, 128'd1);
    check_eq("rst_valid", {127'b0, o_rk_valid}, 128'd0);
    check_eq("rst_rk", o_rk, 128'd0);
    check_eq("rst_idx", {124'b0, o_rk_idx}, 128'd0);
    check_eq("rst_last", {127'b0, o_rk_last}, 128'd0);
    rst_n = 1'b1;

    start(KEY_A1);
    drain(KEY_A1, 100, 1'b0, '0);
    check_eq("a1_rk0", got_rk[0], KEY_A1);
    check_eq("a1_rk1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check_eq("a1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_eq("a1_consecutive", 128'(vcyc), 128'd11);

    start('0);
    drain('0, 100, 1'b0, '0);
    check_eq("zero_rk1", got_rk[1], 128'h62636363626363636263636362636363);
    check_eq("zero_rk10", got_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    start(KEY_SEQ);
    drain(KEY_SEQ, 50, 1'b0, '0);
    check_eq("seq_rk10", got_rk[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);

    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = {$urandom, $urandom, $urandom, $urandom};
    start(k1);
    drain(k1, 100, 1'b1, k2);
    drain(k2, 100, 1'b0, '0);
    check_eq("hold_second_rk0", got_rk[0], k2);
    check_eq("hold_second_len", 128'(vcyc), 128'd11);

    for (int n = 0; n < 6; n++) begin
      k1 = {$urandom, $urandom, $urandom, $urandom};
      start(k1);
      drain(k1, $urandom_range(100, 30), 1'b0, '0);
    end

    expand(KEY_A1);
    start(KEY_A1);
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      i_key_valid = 1'b0;
      if (o_rk_valid && o_rk_idx == 4'd5) begin
        i_rk_ready = 1'b0;
        found = 1'b1;
      end else begin
        i_rk_ready = 1'b1;
      end
    end
    check_eq("mid_reached_rk5", {127'b0, found}, 128'd1);
    check_eq("mid_rk5", o_rk, model_rk[5]);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_valid", {127'b0, o_rk_valid}, 128'd0);
    check_eq("async_rk", o_rk, 128'd0);
    check_eq("async_idx", {124'b0, o_rk_idx}, 128'd0);
    check_eq("async_last", {127'b0, o_rk_last}, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_key_ready", {127'b0, o_key_ready}, 128'd1);
    check_eq("post_rst_valid", {127'b0, o_rk_valid}, 128'd0);
    start(KEY_A1);
    drain(KEY_A1, 100, 1'b0, '0);
    check_eq("post_rst_a1_rk10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
